// File: rtl/env_pkg.sv
// rtl/env_pkg.sv - shared widths, frame geometry, cell types and scan states
// Purpose: common definitions for the environment scan sequencer and its helpers.
// Ports: none (package).
package env_pkg;

  localparam int X_bits   = 10;
  localparam int Y_bits   = 9;
  localparam int PIXELS_X = 640;
  localparam int PIXELS_Y = 480;
  localparam int D_bits   = 8;

  typedef struct packed {
    logic [X_bits-1:0] x;
    logic [Y_bits-1:0] y;
  } loc_t;

  typedef struct packed {
    loc_t              loc;
    logic [D_bits-1:0] data;
  } cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/loc_next.sv
// rtl/loc_next.sv - combinational next raster location and last-cell flag
// Purpose: given the current (x,y), produce the following cell in raster order
//   (x fastest) and flag the final cell of the frame.
// Ports:
//   x, y     in   current location
//   nx, ny   out  next location (wraps to 0,0 after the last cell)
//   last     out  current location is (PIXELS_X-1, PIXELS_Y-1)
module loc_next
  import env_pkg::*;
#(
  parameter int PIXELS_X = env_pkg::PIXELS_X,
  parameter int PIXELS_Y = env_pkg::PIXELS_Y
) (
  input  logic [X_bits-1:0] x,
  input  logic [Y_bits-1:0] y,
  output logic [X_bits-1:0] nx,
  output logic [Y_bits-1:0] ny,
  output logic              last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == X_bits'(PIXELS_X - 1));
  assign y_end = (y == Y_bits'(PIXELS_Y - 1));
  assign last  = x_end & y_end;

  always_comb begin
    nx = x + 1'b1;
    ny = y;
    if (x_end) begin
      nx = '0;
      ny = y_end ? '0 : y + 1'b1;
    end
  end

endmodule

// File: rtl/env_scan_sequencer.sv
// rtl/env_scan_sequencer.sv - per-frame raster walk of env RAM with tagged output stream
// Purpose: on start, read every environment cell once in raster order and return each
//   read result tagged with its (x,y) over a valid/ready stream.
// Ports:
//   Clk, Reset_n            clock, synchronous active-low reset
//   start                   frame start pulse (only honoured in IDLE)
//   rd_req/rd_gnt           RAM read handshake; rd_x/rd_y address
//   rd_data                 RAM data, MEM_LAT cycles after an accepted request
//   out_valid/out_ready     downstream handshake; out_x/out_y/out_data payload
//   busy                    frame in progress
//   frame_done              one-cycle pulse once the last cell has been consumed
module env_scan_sequencer
  import env_pkg::*;
#(
  parameter int PIXELS_X = env_pkg::PIXELS_X,
  parameter int PIXELS_Y = env_pkg::PIXELS_Y,
  parameter int MEM_LAT  = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [X_bits-1:0] rd_x,
  output logic [Y_bits-1:0] rd_y,
  input  logic [D_bits-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X_bits-1:0] out_x,
  output logic [Y_bits-1:0] out_y,
  output logic [D_bits-1:0] out_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int FIFO_DEPTH = MEM_LAT + 2;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  scan_state_t state, state_nxt;

  loc_t              loc;
  logic [X_bits-1:0] nx;
  logic [Y_bits-1:0] ny;
  logic              last_cell;

  // Tag pipe: one slot per RAM latency cycle, valid bit qualifies the location.
  logic [MEM_LAT-1:0] tag_vld;
  loc_t               tag_loc [MEM_LAT];

  cell_t         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  // Credits count free FIFO slots not already claimed by reads in flight.
  logic [CW-1:0] credits;

  logic accept, push, pop, pipe_empty, drain_done, can_issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  loc_next #(
    .PIXELS_X(PIXELS_X),
    .PIXELS_Y(PIXELS_Y)
  ) u_loc_next (
    .x   (loc.x),
    .y   (loc.y),
    .nx  (nx),
    .ny  (ny),
    .last(last_cell)
  );

  assign can_issue  = (state == ISSUE) && (credits != '0);
  assign accept     = can_issue & rd_gnt;
  assign push       = tag_vld[MEM_LAT-1];
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign pipe_empty = (tag_vld == '0);
  // Finish as soon as the final element leaves, so frame_done lands the cycle after it.
  assign drain_done = pipe_empty && ((count == '0) || ((count == CW'(1)) && pop));

  assign rd_x     = loc.x;
  assign rd_y     = loc.y;
  assign out_x    = out_valid ? fifo_mem[rptr].loc.x : '0;
  assign out_y    = out_valid ? fifo_mem[rptr].loc.y : '0;
  assign out_data = out_valid ? fifo_mem[rptr].data  : '0;

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rd_req     = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        rd_req = can_issue;
        if (can_issue && rd_gnt && last_cell) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      loc     <= '0;
      tag_vld <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      credits <= CW'(FIFO_DEPTH);
    end else begin
      if (accept) begin
        loc.x <= nx;
        loc.y <= ny;
      end
      tag_vld[0] <= accept;
      for (int i = 1; i < MEM_LAT; i++) tag_vld[i] <= tag_vld[i-1];
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({accept, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Payload storage needs no reset; valid bits and the FIFO count qualify it.
  always_ff @(posedge Clk) begin
    tag_loc[0] <= loc;
    for (int i = 1; i < MEM_LAT; i++) tag_loc[i] <= tag_loc[i-1];
    if (push) begin
      fifo_mem[wptr].loc  <= tag_loc[MEM_LAT-1];
      fifo_mem[wptr].data <= rd_data;
    end
    if (Reset_n && push) assert (count != CW'(FIFO_DEPTH));
  end

endmodule
